// File: rtl/ultrascan_report_collector_pkg.sv
// ultrascan report collector: shared types, record layout and width helpers.
// Record layout is {is_eod, offset, bitmap}, MSB first.
package ultrascan_report_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EOD_PUSH,
    S_DONE
  } state_t;

  localparam int DEF_N_REPORTS = 1;
  localparam int DEF_OFFSET_W  = 32;

  typedef struct packed {
    logic                     is_eod;
    logic [DEF_OFFSET_W-1:0]  offset;
    logic [DEF_N_REPORTS-1:0] bitmap;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  function automatic int rec_w(input int n_rep, input int off_w);
    return 1 + off_w + n_rep;
  endfunction

  function automatic int eod_bit(input int n_rep, input int off_w);
    return off_w + n_rep;
  endfunction

endpackage

// File: rtl/ultrascan_report_collector_if.sv
// ultrascan report collector: record stream towards the host-side writer.
// master drives m_valid/m_data, slave drives m_ready.
interface ultrascan_report_collector_if #(
  parameter int N_REPORTS = 1,
  parameter int OFFSET_W  = 32
);

  logic                        m_valid;
  logic                        m_ready;
  logic [OFFSET_W+N_REPORTS:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/ultrascan_report_collector_fifo.sv
// ultrascan report collector: show-ahead record FIFO.
// A pop in the same cycle frees room for a push into a full FIFO.
module ultrascan_report_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [W-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)
        r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush)
      r_mem[r_wr[AW-1:0]] <= i_data;
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/ultrascan_report_collector.sv
// ultrascan report collector: tags automaton reports with symbol offsets.
// ULTRASCAN_REPORT_DEDUP_EN suppresses runs of identical consecutive reports.
module ultrascan_report_collector
  import ultrascan_report_pkg::*;
#(
  parameter int N_REPORTS  = 1,
  parameter int OFFSET_W   = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 run,
  input  logic                 eod,
  input  logic [N_REPORTS-1:0] report,
  ultrascan_report_collector_if.master m_if,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_count,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = rec_w(N_REPORTS, OFFSET_W);

  state_t              r_state;
  logic [OFFSET_W-1:0] r_offset;
  logic [OFFSET_W-1:0] r_sym_off;
  logic                r_run_d;
  logic                r_eod_d;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop;
  logic                r_busy;
  logic                r_done;

  logic          w_full;
  logic          w_empty;
  logic [RW-1:0] w_head;
  logic          w_pop;
  logic          w_space;
  logic          w_rep_hit;
  logic          w_dup;
  logic          w_rep_push;
  logic          w_eod_st;
  logic          w_push;
  logic          w_drop;
  logic          w_flush;
  logic [RW-1:0] w_rec;

  assign w_pop     = m_if.m_ready && !w_empty;
  assign w_space   = !w_full || w_pop;
  assign w_rep_hit = (r_state == S_SCAN) && r_run_d && (|report);
  assign w_eod_st  = (r_state == S_EOD_PUSH);

`ifdef ULTRASCAN_REPORT_DEDUP_EN
  logic                 r_last_vld;
  logic [N_REPORTS-1:0] r_last_bmp;
  logic [OFFSET_W-1:0]  r_last_off;

  assign w_dup = r_last_vld &&
                 (report == r_last_bmp) &&
                 (r_sym_off == r_last_off + OFFSET_W'(1));

  // Suppressed reports advance the run so a whole run collapses to one record
  always_ff @(posedge clk) begin
    if (!reset || start) begin
      r_last_vld <= 1'b0;
      r_last_bmp <= '0;
      r_last_off <= '0;
    end else if (w_rep_hit && (w_dup || w_space)) begin
      r_last_vld <= 1'b1;
      r_last_bmp <= report;
      r_last_off <= r_sym_off;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_rep_push = w_rep_hit && !w_dup;
  assign w_push     = (w_rep_push || w_eod_st) && w_space;
  assign w_drop     = w_rep_push && !w_space;
  assign w_flush    = start &&
                      ((r_state == S_SCAN) || w_eod_st);

  assign w_rec = w_eod_st ?
                 {1'b1, r_offset, {N_REPORTS{1'b0}}} :
                 {1'b0, r_sym_off, report};

  ultrascan_report_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (m_if.m_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (w_head)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_offset   <= '0;
      r_sym_off  <= '0;
      r_run_d    <= 1'b0;
      r_eod_d    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (start) begin
      r_state    <= S_SCAN;
      r_offset   <= '0;
      r_sym_off  <= '0;
      r_run_d    <= 1'b0;
      r_eod_d    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_run_d <= 1'b0;
      unique case (r_state)
        S_IDLE: ;
        S_SCAN: begin
          if (run) begin
            r_offset  <= r_offset + OFFSET_W'(1);
            r_sym_off <= r_offset;
            r_run_d   <= 1'b1;
          end
          if (eod)
            r_eod_d <= 1'b1;
          // The report for the eod symbol is sampled in this cycle
          if (r_eod_d) begin
            r_eod_d <= 1'b0;
            r_state <= S_EOD_PUSH;
          end
          if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop != {DROP_W{1'b1}})
              r_drop <= r_drop + DROP_W'(1);
          end
        end
        S_EOD_PUSH: begin
          if (w_space) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: ;
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign m_if.m_valid = !w_empty;
  assign m_if.m_data  = w_head;
  assign overflow     = r_overflow;
  assign drop_count   = r_drop;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: doc/ultrascan_report_collector.md
Name: ultrascan_report_collector

Overview:
- Sits directly downstream of an Automata_* instance. Samples its report wire(s) on every symbol cycle.
- Tags each report with the byte offset of the symbol that fired it, then buffers the record in a FIFO.
- Drains records to the host-side writer over a valid/ready stream.
- Handles end-of-data: emits a terminator record carrying the final symbol count, then signals done.

Parameters:
- N_REPORTS, 1, number of report wires from the automaton; bitmap width.
- OFFSET_W, 32, width of the symbol offset counter and record offset field.
- FIFO_DEPTH, 16, record FIFO entries; power of two, minimum 2.
- DROP_W, 16, width of the dropped-record counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; clears offset, drop count and overflow; enters SCAN.
- run  in  1  symbol consumed by the automaton this cycle; same wire that drives the automaton's run.
- eod  in  1  one-cycle pulse; no further run after this cycle.
- report  in  N_REPORTS  automaton report active_state bits.
- m_valid  out  1  record available.
- m_ready  in  1  consumer accepts the record when m_valid && m_ready.
- m_data  out  1+OFFSET_W+N_REPORTS  record {is_eod, offset, bitmap}.
- overflow  out  1  sticky: at least one record dropped since start.
- drop_count  out  DROP_W  dropped records; saturates at all-ones.
- busy  out  1  state is SCAN or EOD_PUSH.
- done  out  1  state is DONE.

Behaviour:
- Reset (reset==0 at a clk edge): FSM=IDLE, FIFO empty, offset=0, run_d=0, eod_d=0.
  - Outputs: m_valid=0, m_data=0, overflow=0, drop_count=0, busy=0, done=0.
- Report alignment: automaton STE outputs are registered, so report for the symbol consumed at cycle t appears at t+1.
  - Collector keeps run_d (run delayed 1) and sym_off (offset of the last consumed symbol).
  - report is sampled only when run_d==1. report while run_d==0 is ignored.
- offset increments on each run cycle in SCAN. It wraps modulo 2^OFFSET_W with no flag.
- Push: in SCAN with run_d==1 and |report != 0, form record {0, sym_off, report}.
  - Simultaneous report bits go into one record, not one record per bit.
- FIFO full at push (after accounting for a same-cycle pop): record dropped.
  - overflow <= 1; drop_count increments, saturating.
  - A same-cycle pop frees space, so push succeeds.
- FSM states:
  - IDLE: ignores run/report/eod. start -> SCAN.
  - SCAN: eod -> set eod_d. On the following cycle, after the final aligned report is sampled, go to EOD_PUSH.
  - EOD_PUSH: push {1, offset, 0}, where offset is the total symbols consumed. If FIFO full, stall in EOD_PUSH; the terminator is never dropped. Push done -> DONE.
  - DONE: holds until all records drain. start -> SCAN (clears counters; FIFO contents are kept).
- start while in SCAN or EOD_PUSH: restart scan, clear offset and counters, flush FIFO.
- run in IDLE or DONE: no offset change, no push.
- Stream interface:
  - m_data/m_valid are driven directly from the FIFO head (show-ahead). Record latency from report sample to m_valid is 1 cycle.
  - m_data is stable while m_valid && !m_ready.
- Throughput: one push and one pop per cycle sustained.

Optional Feature:
- ULTRASCAN_REPORT_DEDUP_EN defined: a report record is suppressed (not pushed, not counted as dropped) when both hold:
  - its bitmap equals the last pushed bitmap;
  - its sym_off equals last pushed offset+1.
  - Runs of consecutive identical reports therefore produce only the first record. The last-pushed state clears on start.
- Undefined: every qualifying report cycle produces a record. No extra registers.

Decomposition:
- Package ultrascan_report_pkg:
  - state enum (IDLE, SCAN, EOD_PUSH, DONE);
  - packed record struct template widths;
  - localparam for record width;
  - is_eod bit position.
- Sub-module ultrascan_report_fifo: synchronous show-ahead FIFO with full/empty and same-cycle push/pop. The collector instantiates it once.

Test Plan:
- Basic tag: start, run for symbols at offsets 0..9, report=1 on the cycle after offset 3 -> one record {0,3,1}, then after eod a record {1,10,0}, done=1.
- Multi-bit (N_REPORTS=4): report=4'b0101 at aligned offset 7 -> single record {0,7,4'b0101}.
- Overflow: FIFO_DEPTH=4, m_ready=0, reports at offsets 0..5 -> 4 records held, overflow=1, drop_count=2. Raise m_ready -> records 0..3 in order.
- EOD stall: FIFO full when eod arrives -> FSM stays EOD_PUSH, busy=1. One pop -> terminator pushed, done=1.
- Backpressure: toggle m_ready randomly during 100 reports -> m_data stable while stalled, no loss or reorder, drop_count=0.
- Dedup (ULTRASCAN_REPORT_DEDUP_EN): report=1 at offsets 5,6,7,9 -> records at 5 and 9 only. Without the macro -> 4 records.
